// File: rtl/fifo_par.sv
// ---------------------------------------------------------------------------
// fifo_par: single-clock synchronous FIFO built on an inferred simple
// dual-port RAM (one write port, one registered read port).  Tracks the
// occupancy level and derives registered full/empty and programmable
// almost-full/almost-empty flags from the next level.  It also keeps sticky
// overflow/underflow error flags.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous reset, active-high
//   wr_en, din   write request and write data
//   rd_en        read request
//   dout         registered read data (holds when no read is accepted)
//   dout_valid   one-cycle pulse when dout carries newly read data
//   full, empty, almost_full, almost_empty   occupancy flags
//   level        current occupancy (0 .. 2**DEPTH)
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
//   clr_err      clears overflow/underflow (a new rejection wins)
// ---------------------------------------------------------------------------
module fifo_par #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 9,
   parameter int AFULL_LEVEL  = 2**DEPTH - 2,
   parameter int AEMPTY_LEVEL = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [DEPTH:0]   level,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int             ENTRIES    = 2**DEPTH;
   localparam logic [DEPTH:0] CAP        = {1'b1, {DEPTH{1'b0}}};
   localparam logic [DEPTH:0] AFULL_LVL  = AFULL_LEVEL[DEPTH:0];
   localparam logic [DEPTH:0] AEMPTY_LVL = AEMPTY_LEVEL[DEPTH:0];
   localparam logic [DEPTH:0] LVL_ONE    = {{DEPTH{1'b0}}, 1'b1};
   localparam logic [DEPTH-1:0] PTR_ONE  = {{(DEPTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [0:ENTRIES-1];
   logic [DEPTH-1:0] wptr_r;
   logic [DEPTH-1:0] rptr_r;
   logic [DEPTH:0]   level_nxt_s;
   logic             wr_ok_s;
   logic             rd_ok_s;
   logic             wr_rej_s;
   logic             rd_rej_s;

   // Acceptance uses the registered (pre-edge) flags.
   always_comb begin
      wr_ok_s  = wr_en & ~full;
      rd_ok_s  = rd_en & ~empty;
      wr_rej_s = wr_en & full;
      rd_rej_s = rd_en & empty;
   end

   // Next occupancy: simultaneous accepted read and write cancel out.
   always_comb begin
      level_nxt_s = level;
      case ({wr_ok_s, rd_ok_s})
         2'b10:   level_nxt_s = level + LVL_ONE;
         2'b01:   level_nxt_s = level - LVL_ONE;
         default: level_nxt_s = level;
      endcase
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s && !reset) begin
         mem_r[wptr_r] <= din;
      end
   end

   // Pointers, registered read port, level and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r       <= {DEPTH{1'b0}};
         rptr_r       <= {DEPTH{1'b0}};
         dout         <= {WIDTH{1'b0}};
         dout_valid   <= 1'b0;
         level        <= {(DEPTH+1){1'b0}};
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (rd_ok_s) begin
            // A read only happens with level >= 1, so it never targets the
            // slot being written in the same cycle.
            dout   <= mem_r[rptr_r];
            rptr_r <= rptr_r + PTR_ONE;
         end
         dout_valid   <= rd_ok_s;
         level        <= level_nxt_s;
         empty        <= (level_nxt_s == {(DEPTH+1){1'b0}});
         full         <= (level_nxt_s == CAP);
         almost_empty <= (level_nxt_s <= AEMPTY_LVL);
         almost_full  <= (level_nxt_s >= AFULL_LVL);
      end
   end

   // Sticky error flags; a new rejection takes priority over clr_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_rej_s) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rd_rej_s) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_par.sv
// ---------------------------------------------------------------------------
// tb_fifo_par: table-driven self-checking bench for fifo_par with
// WIDTH=8, DEPTH=4, AFULL_LEVEL=14, AEMPTY_LEVEL=2.  Each record holds the
// inputs for one clock and the state expected just after that edge; the
// occupancy flags are derived from the expected level using the thresholds.
// ---------------------------------------------------------------------------
module tb_fifo_par;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] din = 8'h00;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] level;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_par #(
      .WIDTH(8), .DEPTH(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       wr;
      logic [7:0] wdata;
      logic       rd;
      logic       clr;
      logic [4:0] lvl;
      logic [7:0] q;
      logic       qv;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic wr, input logic [7:0] wdata,
                      input logic rd, input logic clr, input logic [4:0] lvl,
                      input logic [7:0] q, input logic qv, input logic ovf,
                      input logic unf);
      vec_t v;
      v.rst = rst; v.wr = wr; v.wdata = wdata; v.rd = rd; v.clr = clr;
      v.lvl = lvl; v.q = q; v.qv = qv; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_state(input int idx, input vec_t v);
      check("level",        idx, 32'(level),        32'(v.lvl));
      check("empty",        idx, 32'(empty),        32'(v.lvl == 5'd0));
      check("full",         idx, 32'(full),         32'(v.lvl == 5'd16));
      check("almost_full",  idx, 32'(almost_full),  32'(v.lvl >= 5'd14));
      check("almost_empty", idx, 32'(almost_empty), 32'(v.lvl <= 5'd2));
      check("dout",         idx, 32'(dout),         32'(v.q));
      check("dout_valid",   idx, 32'(dout_valid),   32'(v.qv));
      check("overflow",     idx, 32'(overflow),     32'(v.ovf));
      check("underflow",    idx, 32'(underflow),    32'(v.unf));
   endtask

   initial begin
      int cycles;

      // ---- reset then idle ----
      add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      // ---- fill with 0x10..0x1F, then rejected write ----
      for (int i = 0; i < 16; i++)
         add(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 5'(i + 1), 8'h00, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd16, 8'h00, 1'b0, 1'b1, 1'b0);
      // ---- drain in order, then rejected read ----
      for (int i = 0; i < 16; i++)
         add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'(15 - i), 8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h1F, 1'b0, 1'b1, 1'b1);
      // clear both errors
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h1F, 1'b0, 1'b0, 1'b0);
      // ---- simultaneous rd/wr when empty ----
      add(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 5'd1, 8'h1F, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h55, 1'b1, 1'b0, 1'b1);
      // rejected read with clr_err in the same cycle: set wins
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h55, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h55, 1'b0, 1'b0, 1'b0);
      // ---- simultaneous rd/wr at level 5 ----
      for (int i = 0; i < 5; i++)
         add(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 5'(i + 1), 8'h55, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h25, 1'b1, 1'b0, 5'd5, 8'h20, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'(4 - i), 8'(8'h21 + i), 1'b1, 1'b0, 1'b0);
      // ---- simultaneous rd/wr when full ----
      for (int i = 0; i < 16; i++)
         add(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 5'(i + 1), 8'h25, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, 5'd15, 8'h30, 1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd15, 8'h30, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++)
         add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'(14 - i), 8'(8'h31 + i), 1'b1, 1'b0, 1'b0);
      // ---- pointer wrap: one write and one read per cycle ----
      add(1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 5'd1, 8'h3F, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++)
         add(1'b0, 1'b1, 8'(8'h41 + i), 1'b1, 1'b0, 5'd1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h68, 1'b1, 1'b0, 1'b0);
      // ---- reset mid-stream at level 7 with rd_en high ----
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h68, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++)
         add(1'b0, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 5'(i + 1), 8'h68, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);

      // ---- apply the table ----
      foreach (vecs[i]) begin
         @(negedge clk);
         reset   = vecs[i].rst;
         wr_en   = vecs[i].wr;
         din     = vecs[i].wdata;
         rd_en   = vecs[i].rd;
         clr_err = vecs[i].clr;
         @(posedge clk);
         #1;
         check_state(i, vecs[i]);
      end

      // ---- hand sequence: read latency and single-cycle dout_valid ----
      @(negedge clk);
      reset = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      wr_en = 1'b1; din = 8'h99;
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b1;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         rd_en = 1'b0;
         cycles++;
      end while (!dout_valid && cycles < 4);
      check("read_latency", -1, 32'(cycles), 32'd1);
      check("latency_dout", -1, 32'(dout), 32'h99);
      @(posedge clk);
      #1;
      check("valid_pulse_end", -1, 32'(dout_valid), 32'd0);
      check("valid_pulse_hold", -1, 32'(dout), 32'h99);
      check("latency_level", -1, 32'(level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
